// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision field definitions, constants and
// classification helpers for the floating-point datapath.
package fp32_pkg;

  localparam int EXP_W      = 8;
  localparam int FRAC_W     = 23;
  localparam int MANT_W     = 24;
  localparam int BIAS       = 127;
  localparam int QUO_W      = 26;
  localparam int REM_W      = 26;
  localparam int DIV_CYCLES = 26;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_INF  = 32'h7F80_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_NORM,
    ST_DONE
  } div_state_e;

  // Subnormals count as zero: only the exponent field decides.
  function automatic logic is_zero(input logic [EXP_W-1:0] e);
    return e == '0;
  endfunction

  function automatic logic is_inf(input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
    return (e == '1) && (f == '0);
  endfunction

  function automatic logic is_nan(input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
    return (e == '1) && (f != '0);
  endfunction

endpackage

// File: rtl/mant_div_step.sv
// One restoring division step: compare/subtract the divisor, emit the
// quotient bit and return the left-shifted partial remainder.
module mant_div_step
  import fp32_pkg::*;
(
  input  logic [REM_W-1:0]  rem_i,
  input  logic [MANT_W-1:0] div_i,
  output logic [REM_W-1:0]  rem_o,
  output logic              q_o
);

  // A remainder that survives subtraction is below the divisor, so 25 bits hold it.
  logic [REM_W-2:0] diff;

  always_comb begin
    q_o   = rem_i >= {2'b00, div_i};
    diff  = rem_i[REM_W-2:0] - {1'b0, div_i};
    rem_o = q_o ? {diff, 1'b0} : {rem_i[REM_W-2:0], 1'b0};
  end

endmodule

// File: rtl/floating_division.sv
// Sequential fp32 divider: one restoring step per cycle, then a single
// normalise/round/special-case cycle, with a start/done handshake.
//
//   state   | meaning
//   IDLE    | waiting for start; operands captured on accept
//   DIV     | 26 cycles, one quotient bit per cycle
//   NORM    | normalise, round to nearest even, special-case mux
//   DONE    | publish result; done pulses as we return to IDLE
module floating_division
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  div_state_e       state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [31:0]      res_q, res_d, result_q, result_d;
  logic [REM_W-1:0] rem_q, rem_d, step_rem;
  logic [QUO_W-1:0] q_q, q_d;
  logic             step_bit;
  logic             done_q, done_d, busy_q, busy_d;

  mant_div_step u_step (
    .rem_i (rem_q),
    .div_i ({1'b1, b_q[FRAC_W-1:0]}),
    .rem_o (step_rem),
    .q_o   (step_bit)
  );

  logic              sign, rnd, sticky, round_up, carry;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [FRAC_W-1:0] frac_pre, frac_rnd;
  logic signed [9:0] exp_s, exp_r;
  logic [31:0]       norm_res;

  always_comb begin
    sign   = a_q[31] ^ b_q[31];
    a_zero = is_zero(a_q[30:23]);
    b_zero = is_zero(b_q[30:23]);
    a_inf  = is_inf(a_q[30:23], a_q[22:0]);
    b_inf  = is_inf(b_q[30:23], b_q[22:0]);
    a_nan  = is_nan(a_q[30:23], a_q[22:0]);
    b_nan  = is_nan(b_q[30:23], b_q[22:0]);

    // A leading quotient bit of 0 means mA < mB: take bits one position lower.
    frac_pre = q_q[QUO_W-1] ? q_q[24:2] : q_q[23:1];
    rnd      = q_q[QUO_W-1] ? q_q[1] : q_q[0];
    sticky   = (q_q[QUO_W-1] & q_q[0]) | (|rem_q);
    round_up = rnd & (sticky | frac_pre[0]);
    {carry, frac_rnd} = {1'b0, frac_pre} + {{FRAC_W{1'b0}}, round_up};

    exp_s = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd127
            - (q_q[QUO_W-1] ? 10'sd0 : 10'sd1);
    exp_r = exp_s + (carry ? 10'sd1 : 10'sd0);

    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      norm_res = FP_QNAN;
    else if (a_inf || b_zero)
      norm_res = FP_INF | {sign, 31'b0};
    else if (a_zero || b_inf)
      norm_res = {sign, 31'b0};
    else if (exp_r >= 10'sd255)
      norm_res = FP_INF | {sign, 31'b0};
    else if (exp_r <= 10'sd0)
      norm_res = {sign, 31'b0};
    else
      norm_res = {sign, exp_r[7:0], frac_rnd};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    q_d      = q_q;
    res_d    = res_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          rem_d   = {3'b001, A[FRAC_W-1:0]};
          q_d     = '0;
          cnt_d   = 5'(DIV_CYCLES - 1);
          busy_d  = 1'b1;
          state_d = ST_DIV;
        end
      end
      ST_DIV: begin
        rem_d = step_rem;
        q_d   = {q_q[QUO_W-2:0], step_bit};
        if (cnt_q == '0) state_d = ST_NORM;
        else             cnt_d   = cnt_q - 5'd1;
      end
      ST_NORM: begin
        res_d   = norm_res;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        result_d = res_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      q_q      <= '0;
      res_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      q_q      <= q_d;
      res_q    <= res_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_floating_division.sv
// Directed bench for floating_division: scoreboard of expected quotients,
// latency/handshake checks and a mid-operation asynchronous reset.
module tb_floating_division;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A     = '0;
  logic [31:0] B     = '0;
  logic        busy, done;
  logic [31:0] result;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  floating_division dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  function automatic real fp_to_real(input logic [31:0] f);
    logic [10:0] e;
    logic [63:0] d;
    if (f[30:23] == 8'h00)      e = 11'h000;
    else if (f[30:23] == 8'hFF) e = 11'h7FF;
    else                        e = 11'(f[30:23]) + 11'd896;
    d = {f[31], e, (f[30:23] == 8'h00) ? 52'h0 : {f[22:0], 29'h0}};
    return $bitstoreal(d);
  endfunction

  task automatic display_float(input string id, input logic [31:0] num, input bit fmt);
    if (fmt) $display("%s 0x%08h = %e", id, num, fp_to_real(num));
    else     $display("%s 0x%08h = %f", id, num, fp_to_real(num));
  endtask

  always @(result) display_float("result", result, 1'b1);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Called at a falling edge; the following rising edge is the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] expv);
    A     = a;
    B     = b;
    start = 1'b1;
    if (push) exp_q.push_back(expv);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("done_low_after_accept", 32'(done), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int lat0);
    int          lat;
    logic [31:0] expv;
    lat = lat0;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_result"}, result, expv);
    check({tag, "_latency"}, 32'(lat), 32'd28);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expv);
    issue(a, b, 1'b1, expv);
    wait_done(tag, 0);
  endtask

  initial begin
    int extra;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("neg_neg", 32'hC0CC_CCCC, 32'hBF00_0000, 32'h414C_CCCC);
    @(negedge clk);
    run_op("pos_neg", 32'h40CC_CCCC, 32'hBF00_0000, 32'hC14C_CCCC);
    // Issued in the done cycle: accepted on the very next edge.
    run_op("one_third_b2b", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB);
    run_op("six_by_three", 32'h40C0_0000, 32'h4040_0000, 32'h4000_0000);
    run_op("zero_num", 32'h0000_0000, 32'h4034_B4B5, 32'h0000_0000);
    run_op("div_by_zero", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000);
    run_op("zero_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000);
    run_op("nan_in", 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000);
    run_op("overflow", 32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000);
    run_op("underflow", 32'h0080_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("neg_by_zero", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000);
    run_op("fin_by_neg_inf", 32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000);
    run_op("subnormal_ftz", 32'h0040_0000, 32'h3F80_0000, 32'h0000_0000);

    @(negedge clk);
    issue(32'hC0CC_CCCC, 32'hBF00_0000, 1'b1, 32'h414C_CCCC);
    repeat (4) @(negedge clk);
    A     = 32'h3F80_0000;
    B     = 32'h4040_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A     = 32'h0000_0000;
    B     = 32'h0000_0000;
    wait_done("ignore_busy", 5);
    extra = 0;
    repeat (35) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("ignore_no_second_done", 32'(extra), 32'd0);

    issue(32'h40C0_0000, 32'h4040_0000, 1'b0, 32'h0);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("no_done_after_abort", 32'(extra), 32'd0);
    run_op("post_reset", 32'h40C0_0000, 32'h4040_0000, 32'h4000_0000);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
